// File: rtl/axicb_rd_ostdg_ctrl.sv
// Read admission controller: limits outstanding reads to MAX_OSTDG, all to one slave route.
// Optional watchdog enabled by defining AXICB_RD_OSTDG_TIMEOUT_EN.
module axicb_rd_ostdg_ctrl #(
    parameter int SLV_NB         = 4,
    parameter int MAX_OSTDG      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              srst,
    input  logic              i_arvalid,
    output logic              i_arready,
    input  logic [SLV_NB-1:0] i_artarget,
    output logic              o_arvalid,
    input  logic              o_arready,
    input  logic              r_valid,
    input  logic              r_ready,
    input  logic              r_last,
    output logic [7:0]        o_ostdg_cnt,
    output logic [SLV_NB-1:0] o_cur_target,
    output logic              o_busy,
    output logic              o_underflow,
    output logic              o_timeout
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_FULL   = 2'd2;
    localparam logic [7:0] MAX_CNT  = 8'(MAX_OSTDG);

    logic [1:0]        state, state_nxt;
    logic [7:0]        cnt, cnt_nxt;
    logic [SLV_NB-1:0] cur_target;
    logic              underflow;
    logic              accept_ok, accept, retire;

    // srst forces the reset-time pass-through even before the registers clear
    assign accept_ok = srst || ((state != S_FULL) &&
                                ((state == S_IDLE) || (i_artarget == cur_target)));
    assign o_arvalid = i_arvalid & accept_ok;
    assign i_arready = o_arready & accept_ok;
    assign accept    = i_arvalid & o_arready & accept_ok;
    assign retire    = r_valid & r_ready & r_last;

    always_comb begin
        cnt_nxt = cnt;
        if (state == S_IDLE)
            cnt_nxt = accept ? 8'd1 : 8'd0;
        else if (accept && !retire)
            cnt_nxt = cnt + 8'd1;
        else if (retire && !accept)
            cnt_nxt = cnt - 8'd1;
    end

    always_comb begin
        state_nxt = S_ACTIVE;
        if (cnt_nxt == 8'd0)
            state_nxt = S_IDLE;
        else if (cnt_nxt == MAX_CNT)
            state_nxt = S_FULL;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= S_IDLE;
            cnt        <= 8'd0;
            cur_target <= '0;
            underflow  <= 1'b0;
        end else if (srst) begin
            state      <= S_IDLE;
            cnt        <= 8'd0;
            cur_target <= '0;
            underflow  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept && state == S_IDLE)
                cur_target <= i_artarget;
            // a last beat with nothing tracked belongs to a read we never saw
            if (retire && state == S_IDLE)
                underflow <= 1'b1;
        end
    end

    assign o_ostdg_cnt  = cnt;
    assign o_cur_target = cur_target;
    assign o_busy       = (state != S_IDLE);
    assign o_underflow  = underflow;

`ifdef AXICB_RD_OSTDG_TIMEOUT_EN
    localparam int            WDW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT_CYCLES);

    logic [WDW-1:0] wd, wd_inc;
    logic           timeout;

    assign wd_inc = wd + 1'b1;

    // any R beat counts as forward progress, not just the last one
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wd      <= '0;
            timeout <= 1'b0;
        end else if (srst) begin
            wd      <= '0;
            timeout <= 1'b0;
        end else if (state == S_IDLE || (r_valid && r_ready)) begin
            wd <= '0;
        end else if (wd != WD_MAX) begin
            wd <= wd_inc;
            if (wd_inc == WD_MAX)
                timeout <= 1'b1;
        end
    end

    assign o_timeout = timeout;
`else
    assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axicb_rd_ostdg_ctrl.sv
// Scoreboard bench: expected AR acceptances are queued by the stimulus and popped by a monitor.
module tb_axicb_rd_ostdg_ctrl;

    logic       aclk = 1'b0;
    logic       aresetn, srst;
    logic       i_arvalid, i_arready, o_arvalid, o_arready;
    logic [3:0] i_artarget, o_cur_target;
    logic       r_valid, r_ready, r_last;
    logic [7:0] o_ostdg_cnt;
    logic       o_busy, o_underflow, o_timeout;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0] tgt;
        logic [7:0] cnt;
    } exp_t;
    exp_t q[$];

    always #5 aclk = ~aclk;

    axicb_rd_ostdg_ctrl #(.SLV_NB(4), .MAX_OSTDG(4), .TIMEOUT_CYCLES(16)) dut (
        .aclk(aclk), .aresetn(aresetn), .srst(srst),
        .i_arvalid(i_arvalid), .i_arready(i_arready), .i_artarget(i_artarget),
        .o_arvalid(o_arvalid), .o_arready(o_arready),
        .r_valid(r_valid), .r_ready(r_ready), .r_last(r_last),
        .o_ostdg_cnt(o_ostdg_cnt), .o_cur_target(o_cur_target), .o_busy(o_busy),
        .o_underflow(o_underflow), .o_timeout(o_timeout)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] t, input logic [7:0] c);
        exp_t e;
        e.tgt = t;
        e.cnt = c;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic rbeat(input logic last);
        r_valid = 1'b1; r_ready = 1'b1; r_last = last;
        tick();
        r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0;
    endtask

    task automatic srst_pulse();
        srst = 1'b1;
        tick();
        srst = 1'b0;
    endtask

    // Monitor: every slave-side AR handshake must match the next queued expectation
    always @(negedge aclk) begin
        exp_t e;
        if (aresetn && !srst && o_arvalid && o_arready) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL ar_unexpected: got handshake tgt %0h expected none at %0t", i_artarget, $time);
            end else begin
                e = q.pop_front();
                chk("ar_master_ready", {31'd0, i_arready}, 32'd1);
                chk("ar_target", {28'd0, i_artarget}, {28'd0, e.tgt});
                chk("ar_cnt_before", {24'd0, o_ostdg_cnt}, {24'd0, e.cnt});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL tb_watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        aresetn = 1'b0; srst = 1'b0;
        i_arvalid = 1'b0; o_arready = 1'b0; i_artarget = 4'd0;
        r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0;

        // reset state and pass-through
        #3;
        i_arvalid = 1'b1;
        #1;
        chk("rst_arvalid_pass", {31'd0, o_arvalid}, 32'd1);
        chk("rst_arready_pass0", {31'd0, i_arready}, 32'd0);
        o_arready = 1'b1; i_arvalid = 1'b0;
        #1;
        chk("rst_arready_pass1", {31'd0, i_arready}, 32'd1);
        chk("rst_cnt", {24'd0, o_ostdg_cnt}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_underflow", {31'd0, o_underflow}, 32'd0);
        chk("rst_timeout", {31'd0, o_timeout}, 32'd0);
        chk("rst_target", {28'd0, o_cur_target}, 32'd0);
        tick(); tick();
        aresetn = 1'b1;
        tick();

        // T1: fill to MAX_OSTDG, then one retire frees a slot
        i_artarget = 4'b0010; i_arvalid = 1'b1;
        for (int i = 0; i < 4; i++) push(4'b0010, 8'(i));
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk); chk("t1_fill_ready", {31'd0, i_arready}, 32'd1);
            tick();
        end
        @(negedge aclk);
        chk("t1_full_cnt", {24'd0, o_ostdg_cnt}, 32'd4);
        chk("t1_full_ready", {31'd0, i_arready}, 32'd0);
        chk("t1_full_arvalid", {31'd0, o_arvalid}, 32'd0);
        chk("t1_full_target", {28'd0, o_cur_target}, 32'h2);
        chk("t1_full_busy", {31'd0, o_busy}, 32'd1);
        tick();
        @(negedge aclk); chk("t1_full_hold", {31'd0, i_arready}, 32'd0);
        tick();
        push(4'b0010, 8'd3);
        r_valid = 1'b1; r_ready = 1'b1; r_last = 1'b1;
        @(negedge aclk); chk("t1_full_on_retire", {31'd0, i_arready}, 32'd0);
        tick();
        r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0;
        @(negedge aclk);
        chk("t1_after_retire_cnt", {24'd0, o_ostdg_cnt}, 32'd3);
        chk("t1_after_retire_ready", {31'd0, i_arready}, 32'd1);
        tick();
        i_arvalid = 1'b0;
        @(negedge aclk); chk("t1_refill_cnt", {24'd0, o_ostdg_cnt}, 32'd4);
        for (int i = 0; i < 4; i++) rbeat(1'b1);
        @(negedge aclk);
        chk("t1_drain_cnt", {24'd0, o_ostdg_cnt}, 32'd0);
        chk("t1_drain_busy", {31'd0, o_busy}, 32'd0);

        // T2: target switch waits for the counter to empty
        i_artarget = 4'b0001; i_arvalid = 1'b1;
        push(4'b0001, 8'd0); push(4'b0001, 8'd1);
        tick(); tick();
        i_artarget = 4'b0100;
        push(4'b0100, 8'd0);
        @(negedge aclk); chk("t2_blocked", {31'd0, i_arready}, 32'd0);
        tick();
        r_valid = 1'b1; r_ready = 1'b1; r_last = 1'b1;
        @(negedge aclk); chk("t2_blocked_retire1", {31'd0, i_arready}, 32'd0);
        tick();
        @(negedge aclk); chk("t2_blocked_retire2", {31'd0, i_arready}, 32'd0);
        tick();
        r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0;
        @(negedge aclk); chk("t2_released", {31'd0, i_arready}, 32'd1);
        tick();
        i_arvalid = 1'b0;
        @(negedge aclk);
        chk("t2_cnt", {24'd0, o_ostdg_cnt}, 32'd1);
        chk("t2_target", {28'd0, o_cur_target}, 32'h4);

        // T3: simultaneous accept and retire at cnt 2
        push(4'b0100, 8'd1); i_arvalid = 1'b1;
        tick();
        push(4'b0100, 8'd2);
        r_valid = 1'b1; r_ready = 1'b1; r_last = 1'b1;
        @(negedge aclk); chk("t3_ready_both", {31'd0, i_arready}, 32'd1);
        tick();
        r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0; i_arvalid = 1'b0;
        @(negedge aclk);
        chk("t3_cnt_same", {24'd0, o_ostdg_cnt}, 32'd2);
        chk("t3_active_ready", {31'd0, i_arready}, 32'd1);
        rbeat(1'b1); rbeat(1'b1);
        @(negedge aclk); chk("t3_drain", {24'd0, o_ostdg_cnt}, 32'd0);

        // T4: misrouted (all-zero) target serialises like any other route
        i_artarget = 4'b0000; i_arvalid = 1'b1; push(4'b0000, 8'd0);
        tick();
        i_artarget = 4'b0001; push(4'b0001, 8'd0);
        @(negedge aclk);
        chk("t4_cnt", {24'd0, o_ostdg_cnt}, 32'd1);
        chk("t4_target_zero", {28'd0, o_cur_target}, 32'h0);
        chk("t4_blocked", {31'd0, i_arready}, 32'd0);
        tick();
        r_valid = 1'b1; r_ready = 1'b1; r_last = 1'b0;
        @(negedge aclk); chk("t4_blocked_nonlast", {31'd0, i_arready}, 32'd0);
        tick();
        r_last = 1'b1;
        @(negedge aclk);
        chk("t4_nonlast_no_retire", {24'd0, o_ostdg_cnt}, 32'd1);
        chk("t4_blocked_retire", {31'd0, i_arready}, 32'd0);
        tick();
        r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0;
        @(negedge aclk); chk("t4_released", {31'd0, i_arready}, 32'd1);
        tick();
        i_arvalid = 1'b0;
        @(negedge aclk);
        chk("t4_new_target", {28'd0, o_cur_target}, 32'h1);
        rbeat(1'b1);
        @(negedge aclk); chk("t4_drain", {24'd0, o_ostdg_cnt}, 32'd0);

        // T5: underflow, srst clear, and srst discarding tracked reads
        rbeat(1'b1);
        @(negedge aclk);
        chk("t5_underflow", {31'd0, o_underflow}, 32'd1);
        chk("t5_no_wrap", {24'd0, o_ostdg_cnt}, 32'd0);
        srst = 1'b1;
        @(negedge aclk); chk("t5_srst_pass", {31'd0, i_arready}, 32'd1);
        tick();
        srst = 1'b0;
        @(negedge aclk); chk("t5_srst_clear", {31'd0, o_underflow}, 32'd0);
        i_artarget = 4'b0010; i_arvalid = 1'b1; push(4'b0010, 8'd0);
        tick();
        i_arvalid = 1'b0;
        srst_pulse();
        @(negedge aclk); chk("t5_srst_cnt", {24'd0, o_ostdg_cnt}, 32'd0);
        rbeat(1'b1);
        @(negedge aclk); chk("t5_stale_underflow", {31'd0, o_underflow}, 32'd1);
        srst_pulse();

`ifdef AXICB_RD_OSTDG_TIMEOUT_EN
        i_artarget = 4'b0010; i_arvalid = 1'b1; push(4'b0010, 8'd0);
        tick();
        i_arvalid = 1'b0;
        repeat (15) tick();
        @(negedge aclk); chk("to_not_yet", {31'd0, o_timeout}, 32'd0);
        tick();
        @(negedge aclk); chk("to_fired", {31'd0, o_timeout}, 32'd1);
        rbeat(1'b1);
        srst_pulse();
        @(negedge aclk); chk("to_srst_clear", {31'd0, o_timeout}, 32'd0);
        i_arvalid = 1'b1; push(4'b0010, 8'd0);
        tick();
        i_arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat (9) tick();
            rbeat(1'b0);
        end
        @(negedge aclk); chk("to_progress_quiet", {31'd0, o_timeout}, 32'd0);
        rbeat(1'b1);
`else
        @(negedge aclk); chk("to_tied_low", {31'd0, o_timeout}, 32'd0);
`endif

        @(negedge aclk);
        chk("end_cnt", {24'd0, o_ostdg_cnt}, 32'd0);
        chk("sb_empty", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axicb_rd_ostdg_ctrl.md
# axicb_rd_ostdg_ctrl

Read-path admission controller placed between a master agent and its slave read switch. It gates the master's AR handshake so at most MAX_OSTDG read transactions are outstanding, and all outstanding reads target a single slave route. This keeps R completions in order without per-ID reorder buffers. It retires transactions by monitoring R-channel last-beat handshakes returned to the master, including DECERR completions for misrouted requests.

## Interface
- SLV_NB, 4, number of slave routes (1..4)
- MAX_OSTDG, 8, max outstanding reads (1..255)
- TIMEOUT_CYCLES, 1024, watchdog threshold in cycles (≥2; used only with the macro)
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- srst  in  1  synchronous reset, active-high
- i_arvalid  in  1  AR valid from master
- i_arready  out  1  AR ready to master
- i_artarget  in  SLV_NB  one-hot decoded target; all-zero = misrouted (DECERR path)
- o_arvalid  out  1  AR valid to slave switch
- o_arready  in  1  AR ready from slave switch
- r_valid  in  1  R valid seen by master (monitor only)
- r_ready  in  1  R ready from master (monitor only)
- r_last  in  1  R last seen by master (monitor only)
- o_ostdg_cnt  out  8  current outstanding count
- o_cur_target  out  SLV_NB  target of outstanding reads; valid when count > 0
- o_busy  out  1  count > 0
- o_underflow  out  1  sticky: R last retired with count 0
- o_timeout  out  1  sticky watchdog flag (0 when the macro is absent)

## Operation
- FSM states: IDLE (cnt==0), ACTIVE (0<cnt<MAX_OSTDG), FULL (cnt==MAX_OSTDG).
- Transitions follow the count after each update. IDLE→ACTIVE on accept. ACTIVE→FULL when the count reaches MAX_OSTDG. FULL→ACTIVE on retire. ACTIVE→IDLE when the count reaches 0.
- If MAX_OSTDG==1: IDLE→FULL directly.
- accept_ok = (state!=FULL) && (state==IDLE || i_artarget==cur_target). It is computed from registered state only.
- o_arvalid = i_arvalid & accept_ok.
- i_arready = o_arready & accept_ok.
- accept = i_arvalid & o_arready & accept_ok.
- retire = r_valid & r_ready & r_last.
- cnt next: +1 on accept only; −1 on retire only; unchanged on both or neither.
- On accept in IDLE, cur_target ← i_artarget. In any other state, cur_target holds.
- An all-zero target is a legal route value. Misrouted requests are counted and serialised like any other target.
- retire while IDLE: cnt stays 0 (no wrap), o_underflow ← 1. A simultaneous accept still increments cnt to 1.
- cnt never exceeds MAX_OSTDG and never wraps.
- o_underflow clears only on reset or srst.

## Timing
- AR gating is combinational: zero added latency, no AR register stage.
- cnt, state, cur_target and flags update on the aclk edge after the qualifying handshake.
- A retire that empties the counter allows a different target only from the next cycle. In the same cycle, a different-target AR stays blocked.
- A same-target AR is accepted in the same cycle as a retire from FULL? No: FULL blocks on registered state, so the AR is accepted one cycle later.
- Reset values (aresetn low or srst high): cnt=0, state=IDLE, cur_target=0, o_busy=0, o_underflow=0, o_timeout=0.
- During reset, i_arready=o_arready and o_arvalid=i_arvalid (IDLE passes through).
- srst mid-operation discards tracking. Completions arriving later for pre-reset reads set o_underflow; this is the required behaviour.
- Once in the AR path, AXI valid stability is the master's responsibility. The block may drop o_arvalid only while i_arready is low, so no accepted handshake is ever retracted.

## Configuration
- AXICB_RD_OSTDG_TIMEOUT_EN defined: a watchdog counter runs while state!=IDLE.
  - It clears on any r_valid&r_ready beat and whenever IDLE.
  - It saturates at TIMEOUT_CYCLES. On the cycle it reaches TIMEOUT_CYCLES, o_timeout ← 1 (sticky until reset/srst).
  - Gating is unaffected.
- Macro absent: no watchdog logic; o_timeout tied 0.

## Test plan
- MAX_OSTDG=4, o_arready=1, 6 back-to-back ARs to target 4'b0010, no R:
  - 4 accepted on cycles 0-3, cnt=4, FULL, i_arready=0.
  - One R last → cnt=3; 5th AR is accepted on the following cycle.
- Target switch:
  - 2 ARs to 4'b0001 are accepted.
  - AR to 4'b0100 stays blocked until the second retire. It is not accepted on the retire cycle; it is accepted the next cycle, and cur_target=4'b0100.
- Simultaneous accept and retire at cnt=2: cnt stays 2 and state stays ACTIVE.
- Misrouted target 4'b0000: accepted and cnt=1. A following AR to 4'b0001 is blocked until the DECERR completion (r_last) retires.
- r_last handshake with cnt=0: o_underflow=1 and cnt stays 0. Then srst → o_underflow=0.
- With AXICB_RD_OSTDG_TIMEOUT_EN and TIMEOUT_CYCLES=16:
  - One AR accepted and no R for 16 cycles → o_timeout=1.
  - Repeat with one R beat every 10 cycles → o_timeout stays 0.
